// File: rtl/cache_fill_arbiter_pkg.sv
// Shared definitions for the cache block-fill path: fill FSM states and block geometry.
// Imported by the arbiter and by the cache modules that consume fill writes.
package cache_fill_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL_I = 2'd1,
      FILL_D = 2'd2
   } fill_state_e;

   localparam int BLOCK_WORDS    = 8;
   localparam int BLOCK_IDX_W    = $clog2(BLOCK_WORDS);
   // Byte offset within a block of 16-bit words: word index plus the byte-select bit.
   localparam int BLOCK_OFFSET_W = BLOCK_IDX_W + 1;

endpackage

// File: rtl/cache_fill_arbiter_counter.sv
// Fill beat counter: synchronous clear and enable.
// Saturates at MAX so that a stray enable past the end of a block cannot wrap the index.
module fill_counter #(
   parameter int CNT_W = 4,
   parameter int MAX   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;

   // Count register: clear has priority over enable, and the count holds once it reaches MAX.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en && (cnt_r < MAX_C)) begin
         cnt_r <= cnt_r + ONE_C;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the single memory read port between I- and D-cache misses.
// It issues one 8-word block fill per miss and steers the returning words to the granted cache.
module cache_fill_arbiter
   import cache_fill_arbiter_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int WORDS  = BLOCK_WORDS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      icache_miss,
   input  logic [ADDR_W-1:0]         icache_addr,
   input  logic                      dcache_miss,
   input  logic [ADDR_W-1:0]         dcache_addr,
   input  logic                      mem_valid,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      mem_en,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      fill_we_i,
   output logic                      fill_we_d,
   output logic [$clog2(WORDS)-1:0]  fill_idx,
   output logic [DATA_W-1:0]         fill_data,
   output logic                      fill_done_i,
   output logic                      fill_done_d,
   output logic                      busy
);

   localparam int IDX_W  = $clog2(WORDS);
   localparam int CNT_W  = IDX_W + 1;
   localparam int OFF_W  = IDX_W + 1;
   localparam int BASE_W = ADDR_W - OFF_W;

   localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);

   fill_state_e        state_r, state_nxt_s;
   logic [BASE_W-1:0]  base_r, base_nxt_s;
   logic [CNT_W-1:0]   issue_cnt_s, recv_cnt_s;
   logic               idle_s, busy_s, issuing_s, we_s, last_beat_s;

   assign idle_s = (state_r == IDLE);

   fill_counter #(.CNT_W(CNT_W), .MAX(WORDS)) u_issue_cnt (
      .clk (clk),
      .rst (rst),
      .clr (idle_s),
      .en  (issuing_s),
      .cnt (issue_cnt_s)
   );

   fill_counter #(.CNT_W(CNT_W), .MAX(WORDS)) u_recv_cnt (
      .clk (clk),
      .rst (rst),
      .clr (idle_s),
      .en  (we_s),
      .cnt (recv_cnt_s)
   );

   // State and latched block base registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         base_r  <= '0;
      end else begin
         state_r <= state_nxt_s;
         base_r  <= base_nxt_s;
      end
   end

   // Next-state logic: D-side wins in IDLE because the MEM-stage instruction is older.
   always_comb begin
      state_nxt_s = state_r;
      base_nxt_s  = base_r;
      case (state_r)
         IDLE: begin
            if (dcache_miss) begin
               state_nxt_s = FILL_D;
               base_nxt_s  = dcache_addr[ADDR_W-1:OFF_W];
            end else if (icache_miss) begin
               state_nxt_s = FILL_I;
               base_nxt_s  = icache_addr[ADDR_W-1:OFF_W];
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FILL_I, FILL_D: begin
            if (we_s && last_beat_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Output decode; the fill write strobes are masked during reset so an aborted fill writes nothing.
   always_comb begin
      busy_s      = 1'b0;
      issuing_s   = 1'b0;
      we_s        = 1'b0;
      last_beat_s = 1'b0;
      mem_en      = 1'b0;
      mem_addr    = '0;
      fill_we_i   = 1'b0;
      fill_we_d   = 1'b0;
      fill_done_i = 1'b0;
      fill_done_d = 1'b0;
      fill_idx    = '0;
      fill_data   = mem_rdata;
      busy_s      = !idle_s;
      issuing_s   = busy_s && (issue_cnt_s < WORDS_C);
      we_s        = busy_s && mem_valid && !rst;
      last_beat_s = (recv_cnt_s == LAST_C);
      mem_en      = issuing_s;
      if (issuing_s) begin
         mem_addr = {base_r, issue_cnt_s[IDX_W-1:0], 1'b0};
      end else begin
         mem_addr = '0;
      end
      if (busy_s) begin
         fill_idx = recv_cnt_s[IDX_W-1:0];
      end else begin
         fill_idx = '0;
      end
      fill_we_i   = we_s && (state_r == FILL_I);
      fill_we_d   = we_s && (state_r == FILL_D);
      fill_done_i = fill_we_i && last_beat_s;
      fill_done_d = fill_we_d && last_beat_s;
      busy        = busy_s;
   end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed self-checking bench for cache_fill_arbiter, with a fixed-latency memory modelled per cycle.
// Inputs are driven 2 time units after each rising edge, and outputs are sampled 1 unit later.
module tb_cache_fill_arbiter;

   logic        clk, rst;
   logic        icache_miss, dcache_miss, mem_valid;
   logic [15:0] icache_addr, dcache_addr, mem_rdata;
   logic        mem_en, fill_we_i, fill_we_d, fill_done_i, fill_done_d, busy;
   logic [15:0] mem_addr, fill_data;
   logic [2:0]  fill_idx;

   int checks = 0;
   int errors = 0;

   cache_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .icache_miss (icache_miss),
      .icache_addr (icache_addr),
      .dcache_miss (dcache_miss),
      .dcache_addr (dcache_addr),
      .mem_valid   (mem_valid),
      .mem_rdata   (mem_rdata),
      .mem_en      (mem_en),
      .mem_addr    (mem_addr),
      .fill_we_i   (fill_we_i),
      .fill_we_d   (fill_we_d),
      .fill_idx    (fill_idx),
      .fill_data   (fill_data),
      .fill_done_i (fill_done_i),
      .fill_done_d (fill_done_d),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] beat_data(input logic [15:0] base, input int b);
      return (base ^ 16'h5A00) + 16'(b * 3 + 1);
   endfunction

   task automatic next_cycle;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      icache_miss = 1'b0; dcache_miss = 1'b0; mem_valid = 1'b0;
      icache_addr = 16'h0000; dcache_addr = 16'h0000; mem_rdata = 16'h0000;
      next_cycle;
      next_cycle;
      #1;
      checks++;
      if ({mem_en, busy, fill_we_i, fill_we_d, fill_done_i, fill_done_d} !== 6'b000000 ||
          mem_addr !== 16'h0000 || fill_idx !== 3'd0) begin
         errors++;
         $display("FAIL reset_outputs: ctrl=%b addr=%h idx=%0d, required all zero",
                  {mem_en, busy, fill_we_i, fill_we_d, fill_done_i, fill_done_d}, mem_addr, fill_idx);
      end
      rst = 1'b0;
      next_cycle;
      for (int i = 0; i < 6; i++) begin
         mem_valid = (i % 2 == 0);
         mem_rdata = 16'hBEEF;
         #1;
         checks++;
         if ({mem_en, busy, fill_we_i, fill_we_d, fill_done_i, fill_done_d} !== 6'b000000 ||
             mem_addr !== 16'h0000 || fill_idx !== 3'd0) begin
            errors++;
            $display("FAIL idle_stray_valid[%0d]: ctrl=%b addr=%h idx=%0d, required all zero",
                     i, {mem_en, busy, fill_we_i, fill_we_d, fill_done_i, fill_done_d}, mem_addr, fill_idx);
         end
         next_cycle;
      end
      mem_valid = 1'b0;
   endtask

   // Runs one complete fill from the IDLE cycle (k=0) through the done cycle and checks every cycle.
   task automatic do_fill(input string name, input bit is_d,
                          input logic i_m, input logic [15:0] i_a,
                          input logic d_m, input logic [15:0] d_a,
                          input int lat, input int stall_beat,
                          input int raise_d_k, input logic [15:0] raise_d_a);
      logic [15:0] base, exp_addr;
      logic [5:0]  exp_ctrl;
      int          last, b;
      logic        exp_en, exp_busy, exp_we, exp_done;
      base = is_d ? {d_a[15:4], 4'h0} : {i_a[15:4], 4'h0};
      last = 8 + lat + ((stall_beat <= 7) ? 1 : 0);
      for (int k = 0; k <= last; k++) begin
         if (k == 0) begin
            icache_miss = i_m; icache_addr = i_a;
            dcache_miss = d_m; dcache_addr = d_a;
         end
         if (k == raise_d_k) begin
            dcache_miss = 1'b1; dcache_addr = raise_d_a;
         end
         b = -1;
         for (int bb = 0; bb < 8; bb++) begin
            if (k == 1 + bb + lat + ((bb >= stall_beat) ? 1 : 0)) b = bb;
         end
         mem_valid = (b >= 0);
         mem_rdata = (b >= 0) ? beat_data(base, b) : 16'h0000;
         exp_en   = (k >= 1) && (k <= 8);
         exp_busy = (k >= 1) && (k <= last);
         exp_we   = (b >= 0);
         exp_done = (b == 7);
         exp_addr = exp_en ? base + 16'((k - 1) * 2) : 16'h0000;
         exp_ctrl = {exp_en, exp_busy, exp_we && !is_d, exp_we && is_d, exp_done && !is_d, exp_done && is_d};
         #1;
         checks++;
         if ({mem_en, busy, fill_we_i, fill_we_d, fill_done_i, fill_done_d} !== exp_ctrl) begin
            errors++;
            $display("FAIL %s ctrl k=%0d: got en,busy,we_i,we_d,done_i,done_d=%b required %b",
                     name, k, {mem_en, busy, fill_we_i, fill_we_d, fill_done_i, fill_done_d}, exp_ctrl);
         end
         checks++;
         if (mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s mem_addr k=%0d: got %h required %h", name, k, mem_addr, exp_addr);
         end
         if (exp_we) begin
            checks++;
            if (fill_idx !== 3'(b) || fill_data !== beat_data(base, b)) begin
               errors++;
               $display("FAIL %s beat k=%0d: got idx=%0d data=%h required idx=%0d data=%h",
                        name, k, fill_idx, fill_data, b, beat_data(base, b));
            end
         end
         next_cycle;
      end
      mem_valid = 1'b0;
   endtask

   task automatic test_icache_fill;
      do_fill("ifill", 1'b0, 1'b1, 16'h1236, 1'b0, 16'h0000, 4, 8, -1, 16'h0000);
      icache_miss = 1'b0;
      #1;
      checks++;
      if ({mem_en, busy, fill_we_i, fill_we_d, fill_done_i, fill_done_d} !== 6'b000000) begin
         errors++;
         $display("FAIL ifill_after_done: ctrl=%b required 000000",
                  {mem_en, busy, fill_we_i, fill_we_d, fill_done_i, fill_done_d});
      end
      next_cycle;
   endtask

   task automatic test_back_to_back;
      do_fill("b2b_d", 1'b1, 1'b1, 16'h0040, 1'b1, 16'h8008, 4, 8, -1, 16'h0000);
      do_fill("b2b_i", 1'b0, 1'b1, 16'h0040, 1'b0, 16'h8008, 4, 8, -1, 16'h0000);
      icache_miss = 1'b0;
      next_cycle;
   endtask

   task automatic test_no_preempt;
      do_fill("nopre_i", 1'b0, 1'b1, 16'h1000, 1'b0, 16'h0000, 4, 8, 3, 16'h4446);
      do_fill("nopre_d", 1'b1, 1'b0, 16'h1000, 1'b1, 16'h4446, 4, 8, -1, 16'h0000);
      dcache_miss = 1'b0;
      next_cycle;
   endtask

   task automatic test_irregular;
      do_fill("stall_d", 1'b1, 1'b0, 16'h0000, 1'b1, 16'h7770, 3, 4, -1, 16'h0000);
      dcache_miss = 1'b0;
      next_cycle;
   endtask

   task automatic test_reset_mid_fill;
      int b;
      for (int k = 0; k <= 13; k++) begin
         if (k == 0) begin
            icache_miss = 1'b1; icache_addr = 16'h2222; dcache_miss = 1'b0;
         end
         if (k == 9) begin
            rst = 1'b1; icache_miss = 1'b0;
         end
         if (k == 10) rst = 1'b0;
         b = k - 5;
         mem_valid = (k >= 5) && (k <= 12);
         mem_rdata = beat_data(16'h2220, b);
         #1;
         if (k >= 5 && k <= 8) begin
            checks++;
            if (fill_we_i !== 1'b1 || fill_idx !== 3'(b) || fill_done_i !== 1'b0) begin
               errors++;
               $display("FAIL abort_pre k=%0d: got we_i=%b idx=%0d done_i=%b required 1,%0d,0",
                        k, fill_we_i, fill_idx, fill_done_i, b);
            end
         end
         if (k >= 10) begin
            checks++;
            if ({mem_en, busy, fill_we_i, fill_we_d, fill_done_i, fill_done_d} !== 6'b000000) begin
               errors++;
               $display("FAIL abort_post k=%0d: ctrl=%b required 000000",
                        k, {mem_en, busy, fill_we_i, fill_we_d, fill_done_i, fill_done_d});
            end
         end
         next_cycle;
      end
      mem_valid = 1'b0;
      do_fill("refill", 1'b0, 1'b1, 16'h2224, 1'b0, 16'h0000, 4, 8, -1, 16'h0000);
      icache_miss = 1'b0;
      next_cycle;
   endtask

   initial begin
      rst = 1'b1;
      icache_miss = 1'b0; dcache_miss = 1'b0; mem_valid = 1'b0;
      icache_addr = 16'h0000; dcache_addr = 16'h0000; mem_rdata = 16'h0000;
      @(posedge clk);
      #2;
      test_reset;
      test_icache_fill;
      test_back_to_back;
      test_no_preempt;
      test_irregular;
      test_reset_mid_fill;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
